// File: rtl/chimp_take2_control.sv
// Sequencing FSM for the chimp-test board: clear, random placement, timed reveal,
// pick tracking, and level/strike/score bookkeeping.
//
// state     | meaning
// IDLE      | waiting for start, board held in reset
// CLEAR     | one-cycle board clear, pick counter back to 1
// LOAD      | datapath placing numbers at oRandNum
// SHOW      | numbers visible while the reveal timer runs
// PLAY      | numbers hidden, player picking in order
// LEVEL_UP  | one-cycle round completion bookkeeping
// STRIKE    | one-cycle wrong-pick bookkeeping
// GAME_OVER | board revealed until restart
module chimp_take2_control #(
  parameter int START_LEVEL = 4,
  parameter int MAX_LEVEL = 25,
  parameter int MAX_STRIKES = 3,
  parameter int SHOW_CYCLES = 50000000,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       iResetn,
  input  logic       iStart,
  input  logic       iDoneLoad,
  input  logic       iChoseCorrectNum,
  input  logic       iChoseWrongNum,
  output logic       oResetBoard,
  output logic       oLoadEnable,
  output logic       oShowEnable,
  output logic [7:0] oRandNum,
  output logic [4:0] oLevel,
  output logic [4:0] oNumToChoose,
  output logic [2:0] oStrikes,
  output logic [5:0] oScore,
  output logic       oGameOver,
  output logic       oWin,
  output logic [3:0] oState
);

  localparam int TW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);
  localparam logic [4:0] START_LV = 5'(START_LEVEL);
  localparam logic [4:0] MAX_LV = 5'(MAX_LEVEL);
  localparam logic [2:0] MAX_STR = 3'(MAX_STRIKES);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CLEAR     = 4'd1;
  localparam logic [3:0] S_LOAD      = 4'd2;
  localparam logic [3:0] S_SHOW      = 4'd3;
  localparam logic [3:0] S_PLAY      = 4'd4;
  localparam logic [3:0] S_LEVEL_UP  = 4'd5;
  localparam logic [3:0] S_STRIKE    = 4'd6;
  localparam logic [3:0] S_GAME_OVER = 4'd7;

  logic [3:0]    state, nextState;
  logic [7:0]    lfsr;
  logic          lfsrFb;
  logic          corrPrev, wrongPrev, corrEdge, wrongEdge;
  logic          loadArmed;
  logic [TW-1:0] showTimer;
  logic          lastNum;

  // XNOR feedback on taps 8,6,5,4; its lock-up value 8'hFF is never reached from the seed
  assign lfsrFb    = ~(lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]);
  assign corrEdge  = iChoseCorrectNum & ~corrPrev;
  assign wrongEdge = iChoseWrongNum & ~wrongPrev;
  assign lastNum   = (oNumToChoose == oLevel);
  assign oRandNum  = lfsr;
  assign oState    = state;

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE, S_GAME_OVER: if (iStart) nextState = S_CLEAR;
      S_CLEAR:    nextState = S_LOAD;
      S_LOAD:     if (loadArmed && iDoneLoad) nextState = S_SHOW;
      S_SHOW: begin
        if (wrongEdge)              nextState = S_STRIKE;
        else if (corrEdge)          nextState = lastNum ? S_LEVEL_UP : S_PLAY;
        else if (showTimer == '0)   nextState = S_PLAY;
      end
      S_PLAY: begin
        if (wrongEdge)              nextState = S_STRIKE;
        else if (corrEdge && lastNum) nextState = S_LEVEL_UP;
      end
      S_LEVEL_UP: nextState = (oLevel == MAX_LV) ? S_GAME_OVER : S_CLEAR;
      S_STRIKE:   nextState = ((oStrikes + 3'd1) == MAX_STR) ? S_GAME_OVER : S_CLEAR;
      default:    nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state        <= S_IDLE;
      lfsr         <= LFSR_SEED;
      corrPrev     <= 1'b0;
      wrongPrev    <= 1'b0;
      loadArmed    <= 1'b0;
      showTimer    <= '0;
      oResetBoard  <= 1'b1;
      oLoadEnable  <= 1'b0;
      oShowEnable  <= 1'b0;
      oLevel       <= START_LV;
      oNumToChoose <= 5'd1;
      oStrikes     <= 3'd0;
      oScore       <= 6'd0;
      oGameOver    <= 1'b0;
      oWin         <= 1'b0;
    end else begin
      state       <= nextState;
      lfsr        <= {lfsr[6:0], lfsrFb};
      corrPrev    <= iChoseCorrectNum;
      wrongPrev   <= iChoseWrongNum;
      // the datapath done flag is stale during the first LOAD cycle
      loadArmed   <= (state == S_LOAD);
      oResetBoard <= (nextState == S_IDLE) || (nextState == S_CLEAR);
      oLoadEnable <= (nextState == S_LOAD);
      oShowEnable <= (nextState == S_SHOW) || (nextState == S_GAME_OVER);
      case (state)
        S_IDLE, S_GAME_OVER: begin
          if (iStart) begin
            oLevel    <= START_LV;
            oStrikes  <= 3'd0;
            oScore    <= 6'd0;
            oGameOver <= 1'b0;
            oWin      <= 1'b0;
          end
        end
        S_CLEAR: oNumToChoose <= 5'd1;
        S_LOAD: begin
          if (nextState == S_SHOW) showTimer <= SHOW_LOAD;
        end
        S_SHOW: begin
          if (showTimer != '0) showTimer <= showTimer - TW'(1);
          if (!wrongEdge && corrEdge && !lastNum) oNumToChoose <= oNumToChoose + 5'd1;
        end
        S_PLAY: begin
          if (!wrongEdge && corrEdge && !lastNum) oNumToChoose <= oNumToChoose + 5'd1;
        end
        S_LEVEL_UP: begin
          if (oScore != 6'd63) oScore <= oScore + 6'd1;
          if (oLevel == MAX_LV) begin
            oWin      <= 1'b1;
            oGameOver <= 1'b1;
          end else begin
            oLevel <= oLevel + 5'd1;
          end
        end
        S_STRIKE: begin
          oStrikes <= oStrikes + 3'd1;
          if (nextState == S_GAME_OVER) oGameOver <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chimp_take2_control.sv
// Scoreboard bench for chimp_take2_control: a round-level model predicts every
// change of the visible outputs with its cycle stamp; a monitor pops and compares.
module tb_chimp_take2_control;

  localparam int SL = 2;
  localparam int ML = 3;
  localparam int MS = 2;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic iResetn = 1'b0;
  logic iStart = 1'b0, iDoneLoad = 1'b0, iChoseCorrectNum = 1'b0, iChoseWrongNum = 1'b0;
  logic oResetBoard, oLoadEnable, oShowEnable, oGameOver, oWin;
  logic [7:0] oRandNum;
  logic [4:0] oLevel, oNumToChoose;
  logic [2:0] oStrikes;
  logic [5:0] oScore;
  logic [3:0] oState;

  always #5 clk = ~clk;

  chimp_take2_control #(
    .START_LEVEL(SL), .MAX_LEVEL(ML), .MAX_STRIKES(MS), .SHOW_CYCLES(SC), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .iResetn(iResetn), .iStart(iStart), .iDoneLoad(iDoneLoad),
    .iChoseCorrectNum(iChoseCorrectNum), .iChoseWrongNum(iChoseWrongNum),
    .oResetBoard(oResetBoard), .oLoadEnable(oLoadEnable), .oShowEnable(oShowEnable),
    .oRandNum(oRandNum), .oLevel(oLevel), .oNumToChoose(oNumToChoose),
    .oStrikes(oStrikes), .oScore(oScore), .oGameOver(oGameOver), .oWin(oWin),
    .oState(oState)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit monOn = 1'b0;

  typedef struct { int cyc; logic [23:0] t; } exp_t;
  exp_t expQ[$];
  exp_t monExp;
  logic [23:0] monLast, seen;

  typedef enum int {M_IDLE, M_CLEAR, M_LOAD, M_SHOW, M_PLAY, M_LVL, M_STRIKE, M_OVER} mph_t;
  mph_t ph;
  int mLevel, mNum, mStrikes, mScore, loadAge, shown;
  bit mOver, mWin, cPrev, wPrev;
  logic [7:0] mLfsr;
  logic [23:0] mLast;

  wire [23:0] dutTuple = {oLevel, oNumToChoose, oStrikes, oScore,
                          oGameOver, oWin, oShowEnable, oLoadEnable, oResetBoard};

  function automatic logic [23:0] modelTuple();
    bit rb, ld, sh;
    rb = (ph == M_IDLE) || (ph == M_CLEAR);
    ld = (ph == M_LOAD);
    sh = (ph == M_SHOW) || (ph == M_OVER);
    return {5'(mLevel), 5'(mNum), 3'(mStrikes), 6'(mScore), mOver, mWin, sh, ld, rb};
  endfunction

  task automatic modelReset();
    ph = M_IDLE; mLevel = SL; mNum = 1; mStrikes = 0; mScore = 0;
    mOver = 0; mWin = 0; cPrev = 0; wPrev = 0; loadAge = 0; shown = 0;
    mLfsr = 8'hA5;
    mLast = modelTuple();
  endtask

  task automatic modelStep(input bit s, input bit d, input bit c, input bit w);
    bit ce, we, nb;
    ce = c && !cPrev;
    we = w && !wPrev;
    cPrev = c;
    wPrev = w;
    nb = (($countones(mLfsr & 8'hB8) % 2) == 0);
    mLfsr = {mLfsr[6:0], nb};
    case (ph)
      M_IDLE, M_OVER: if (s) begin
        mLevel = SL; mStrikes = 0; mScore = 0; mOver = 0; mWin = 0; ph = M_CLEAR;
      end
      M_CLEAR: begin mNum = 1; loadAge = 0; ph = M_LOAD; end
      M_LOAD: if (loadAge > 0 && d) begin shown = 1; ph = M_SHOW; end else loadAge++;
      M_SHOW: begin
        if (we) ph = M_STRIKE;
        else if (ce) begin
          if (mNum == mLevel) ph = M_LVL;
          else begin mNum++; ph = M_PLAY; end
        end
        else if (shown == SC) ph = M_PLAY;
        else shown++;
      end
      M_PLAY: begin
        if (we) ph = M_STRIKE;
        else if (ce) begin
          if (mNum == mLevel) ph = M_LVL;
          else mNum++;
        end
      end
      M_LVL: begin
        if (mScore < 63) mScore++;
        if (mLevel == ML) begin mWin = 1; mOver = 1; ph = M_OVER; end
        else begin mLevel++; ph = M_CLEAR; end
      end
      M_STRIKE: begin
        mStrikes++;
        if (mStrikes == MS) begin mOver = 1; ph = M_OVER; end
        else ph = M_CLEAR;
      end
      default: ph = M_IDLE;
    endcase
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic cycle(input bit s, input bit d, input bit c, input bit w);
    logic [23:0] t;
    iStart = s; iDoneLoad = d; iChoseCorrectNum = c; iChoseWrongNum = w;
    @(posedge clk);
    cyc++;
    modelStep(s, d, c, w);
    t = modelTuple();
    if (t !== mLast) begin
      expQ.push_back('{cyc, t});
      mLast = t;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      seen = dutTuple;
      if (seen !== monLast) begin
        monLast = seen;
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_unexpected cyc=%0d got=%h want=no change", cyc, seen);
        end else begin
          monExp = expQ.pop_front();
          if (monExp.t !== seen || monExp.cyc != cyc) begin
            failures++;
            $display("FAIL scoreboard got=%h at cyc %0d want=%h at cyc %0d",
                     seen, cyc, monExp.t, monExp.cyc);
          end
        end
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    #1;
    chk("drain_before_reset", expQ.size(), 0);
    monOn = 0;
    iResetn = 0; iStart = 0; iDoneLoad = 0; iChoseCorrectNum = 0; iChoseWrongNum = 0;
    #1;
    chk("rst_resetBoard", oResetBoard, 1);
    chk("rst_loadEnable", oLoadEnable, 0);
    chk("rst_showEnable", oShowEnable, 0);
    chk("rst_level", oLevel, SL);
    chk("rst_numToChoose", oNumToChoose, 1);
    chk("rst_strikes", oStrikes, 0);
    chk("rst_score", oScore, 0);
    chk("rst_gameOver", oGameOver, 0);
    chk("rst_win", oWin, 0);
    chk("rst_lfsr", oRandNum, 8'hA5);
    @(posedge clk);
    #1;
    iResetn = 1;
    modelReset();
    expQ.delete();
    monLast = mLast;
    monOn = 1;
    chk("lfsr_seed", oRandNum, 8'hA5);
    cycle(0, 0, 0, 0);
    chk("lfsr_next", oRandNum, 8'h4B);
  endtask

  initial begin
    bit s, d, c, w;
    modelReset();
    doReset();

    // start, stale done ignored, show timeout
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("clear_then_load", oLoadEnable, 1);
    chk("clear_one_cycle", oResetBoard, 0);
    cycle(0, 1, 0, 0);
    chk("load_first_done_ignored", oLoadEnable, 1);
    cycle(0, 1, 0, 0);
    chk("show_on", oShowEnable, 1);
    repeat (3) cycle(0, 0, 0, 0);
    chk("show_still_on", oShowEnable, 1);
    cycle(0, 0, 0, 0);
    chk("show_timeout_off", oShowEnable, 0);
    chk("show_timeout_num", oNumToChoose, 1);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    chk("lvlup_score", oScore, 1);
    chk("lvlup_level", oLevel, 3);
    chk("lvlup_clear", oResetBoard, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    doReset();

    // early hide on first correct pick
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    chk("early_hide_show", oShowEnable, 0);
    chk("early_hide_num", oNumToChoose, 2);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    chk("lvl2_level", oLevel, 3);
    chk("lvl2_score", oScore, 1);

    // strikes: held wrong level counts once
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    repeat (10) cycle(0, 0, 0, 1);
    chk("held_wrong_strikes", oStrikes, 1);
    chk("held_wrong_load", oLoadEnable, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    chk("gameover_strikes", oStrikes, 2);
    chk("gameover_flag", oGameOver, 1);
    chk("gameover_show", oShowEnable, 1);
    chk("gameover_nowin", oWin, 0);

    // restart, correct during LOAD ignored, simultaneous edges strike
    cycle(1, 0, 0, 0);
    chk("restart_flag", oGameOver, 0);
    chk("restart_level", oLevel, SL);
    chk("restart_strikes", oStrikes, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    chk("load_correct_ignored", oNumToChoose, 1);
    cycle(0, 1, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 0);
    chk("simul_strike", oStrikes, 1);
    chk("simul_num", oNumToChoose, 1);

    // win at MAX_LEVEL
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    chk("win_flag", oWin, 1);
    chk("win_over", oGameOver, 1);
    chk("win_level", oLevel, 3);
    chk("win_score", oScore, 2);
    cycle(1, 0, 0, 0);
    chk("win_restart_level", oLevel, SL);
    chk("win_restart_score", oScore, 0);
    chk("win_restart_win", oWin, 0);
    chk("win_restart_over", oGameOver, 0);

    // randomized play against the model
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) doReset();
      if (ph == M_OVER || ph == M_IDLE) s = ($urandom_range(0, 7) == 0);
      else s = ($urandom_range(0, 63) == 0);
      d = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 3) == 0);
      w = ($urandom_range(0, 11) == 0);
      cycle(s, d, c, w);
    end

    repeat (3) cycle(0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("final_queue_empty", expQ.size(), 0);
    chk("final_lfsr", oRandNum, mLfsr);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
